// File: rtl/bin_enc_stream_pkg.sv
// Shared types and helpers for the streaming multi-hot-to-binary encoder.
// Latency: n/a (types, macros and a pure function only).
// Backpressure: n/a.
`ifndef BIN_ENC_STREAM_PKG_SV
`define BIN_ENC_STREAM_PKG_SV

// Active-level macros: `High/`Low are aliases of the codebase's `Enable/`Enable_.
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif
`ifndef High
`define High `Enable
`endif
`ifndef Low
`define Low `Enable_
`endif

package enc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } enc_state_t;

  // A raw bit counts as "set" when it matches the active level; result is always active-high.
  function automatic logic norm_bit(input logic raw, input logic act);
    return ~(raw ^ act);
  endfunction

endpackage

`endif

// File: rtl/bin_enc_stream_if.sv
// Handshake bundle between a request-vector producer and the index stream.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry stall upstream and downstream.
interface bin_enc_stream_if #(
  parameter int IN = 4
);
  localparam int OUT = 1 << IN;

  logic           in_valid;
  logic           in_ready;
  logic [OUT-1:0] in_vec;
  logic           out_valid;
  logic           out_ready;
  logic [IN-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           zero;

  // Producer/consumer side (drives requests, takes indices).
  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, busy, zero
  );

  // Encoder side.
  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, busy, zero
  );
endinterface

// File: rtl/bin_enc_stream_pri_enc.sv
// Lowest-set-bit priority encoder with any-set and exactly-one-set flags.
// Latency: purely combinational.
// Backpressure: none (no state).
module pri_enc #(
  parameter int IN  = 4,
  parameter int OUT = 1 << IN
) (
  input  logic [OUT-1:0] vec,
  output logic [IN-1:0]  idx,
  output logic           found,
  output logic           single
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    idx = '0;
    for (int i = OUT - 1; i >= 0; i--) begin
      if (vec[i]) idx = IN'(i);
    end
  end

  // Clearing the lowest set bit leaves zero only if it was the only one.
  always_comb begin
    found  = |vec;
    single = found && ((vec & (vec - OUT'(1))) == '0);
  end

endmodule

// File: rtl/bin_enc_stream.sv
// Accepts a multi-hot vector and emits each set bit's index, lowest first, flagging the last.
// Latency: vector accepted at edge t gives first out_valid in cycle t+1; k set bits drain in k cycles.
// Backpressure: out_ready=0 holds out_idx/out_last; in_ready is low for the whole drain.
module bin_enc_stream
  import enc_pkg::*;
#(
  parameter int   IN  = 4,
  parameter logic ACT = `High
) (
  input  logic             clk,
  input  logic             reset,
  bin_enc_stream_if.slave  bus
);

  localparam int OUT = 1 << IN;

  enc_state_t     state;
  enc_state_t     state_nxt;
  logic [OUT-1:0] pending;
  logic [OUT-1:0] pending_nxt;
  logic           zero_q;
  logic           zero_nxt;
  logic [OUT-1:0] norm_vec;
  logic [OUT-1:0] clear_mask;
  logic [IN-1:0]  enc_idx;
  logic           enc_found;
  logic           enc_single;

  pri_enc #(
    .IN  (IN),
    .OUT (OUT)
  ) u_pri_enc (
    .vec    (pending),
    .idx    (enc_idx),
    .found  (enc_found),
    .single (enc_single)
  );

  // Bring the incoming vector to active-high so the rest of the block never sees ACT.
  always_comb begin
    norm_vec = '0;
    for (int i = 0; i < OUT; i++) begin
      norm_vec[i] = norm_bit(bus.in_vec[i], ACT);
    end
  end

  // One-hot mask of the bit currently being presented.
  always_comb begin
    clear_mask = OUT'(1) << enc_idx;
  end

  // Next state: load in IDLE, retire one bit per output handshake in BUSY.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    zero_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          pending_nxt = norm_vec;
          if (|norm_vec) state_nxt = ST_BUSY;
          else           zero_nxt  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (bus.out_ready && enc_found) begin
          pending_nxt = pending & ~clear_mask;
          if (enc_single) state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pending vector and the empty-vector pulse; reset discards any drain in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= '0;
      zero_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      zero_q  <= zero_nxt;
    end
  end

  // Every output comes from registers only: no in_* or out_ready to output paths.
  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_BUSY);
  assign bus.busy      = (state == ST_BUSY);
  assign bus.out_idx   = enc_idx;
  assign bus.out_last  = (state == ST_BUSY) && enc_single;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_bin_enc_stream.sv
// Self-checking bench for bin_enc_stream: directed corners, a vector table and a random drain.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin_enc_stream;

  localparam int IN  = 4;
  localparam int OUT = 1 << IN;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bin_enc_stream_if #(.IN(IN)) hi_if ();
  bin_enc_stream_if #(.IN(IN)) lo_if ();

  bin_enc_stream #(.IN(IN), .ACT(1'b1)) dut_hi (.clk(clk), .reset(reset), .bus(hi_if));
  bin_enc_stream #(.IN(IN), .ACT(1'b0)) dut_lo (.clk(clk), .reset(reset), .bus(lo_if));

  typedef struct {
    logic [OUT-1:0] vec;
    int             count;
    int             first;
    int             last;
  } vec_rec_t;

  vec_rec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random vector with a mix of empty, one-hot, sparse and dense patterns.
  function automatic logic [OUT-1:0] rand_vec();
    int mode;
    mode = int'($urandom_range(0, 3));
    case (mode)
      0:       return '0;
      1:       return OUT'(1) << $urandom_range(0, OUT - 1);
      2:       return OUT'($urandom & $urandom);
      default: return OUT'($urandom);
    endcase
  endfunction

  initial begin
    int q[$];
    int n, lasts, got_first, got_last, exp_i;
    logic zseen, rdy, pend_zero, prev_stall;
    logic [IN-1:0] prev_idx;
    logic [OUT-1:0] v;

    tv[0] = '{vec: 16'h8421, count: 4,  first: 0,  last: 15};
    tv[1] = '{vec: 16'h0001, count: 1,  first: 0,  last: 0};
    tv[2] = '{vec: 16'h8000, count: 1,  first: 15, last: 15};
    tv[3] = '{vec: 16'hFFFF, count: 16, first: 0,  last: 15};
    tv[4] = '{vec: 16'h0000, count: 0,  first: 0,  last: 0};
    tv[5] = '{vec: 16'h0180, count: 2,  first: 7,  last: 8};

    hi_if.in_valid = 1'b0; hi_if.in_vec = '0; hi_if.out_ready = 1'b1;
    lo_if.in_valid = 1'b0; lo_if.in_vec = '1; lo_if.out_ready = 1'b1;

    // ---- reset values ----
    reset = 1'b1;
    step();
    chk("rst_in_ready",  int'(hi_if.in_ready),  1);
    chk("rst_out_valid", int'(hi_if.out_valid), 0);
    chk("rst_out_idx",   int'(hi_if.out_idx),   0);
    chk("rst_out_last",  int'(hi_if.out_last),  0);
    chk("rst_busy",      int'(hi_if.busy),      0);
    chk("rst_zero",      int'(hi_if.zero),      0);
    reset = 1'b0;
    step();

    // ---- full-rate drain of 8421 ----
    hi_if.in_vec = 16'h8421; hi_if.in_valid = 1'b1;
    step();
    hi_if.in_valid = 1'b0;
    chk("fr_in_ready_busy", int'(hi_if.in_ready), 0);
    for (int k = 0; k < 4; k++) begin
      chk("fr_valid", int'(hi_if.out_valid), 1);
      chk("fr_busy",  int'(hi_if.busy), 1);
      chk("fr_idx",   int'(hi_if.out_idx), 5 * k);
      chk("fr_last",  int'(hi_if.out_last), (k == 3) ? 1 : 0);
      step();
    end
    chk("fr_in_ready_after", int'(hi_if.in_ready), 1);
    chk("fr_valid_after",    int'(hi_if.out_valid), 0);

    // ---- backpressure on 0006 ----
    hi_if.in_vec = 16'h0006; hi_if.in_valid = 1'b1; hi_if.out_ready = 1'b0;
    step();
    hi_if.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", int'(hi_if.out_valid), 1);
      chk("bp_hold_idx",   int'(hi_if.out_idx), 1);
      chk("bp_hold_last",  int'(hi_if.out_last), 0);
      step();
    end
    chk("bp_rel_idx", int'(hi_if.out_idx), 1);
    hi_if.out_ready = 1'b1;
    step();
    chk("bp_second_idx",  int'(hi_if.out_idx), 2);
    chk("bp_second_last", int'(hi_if.out_last), 1);
    step();
    chk("bp_done_valid", int'(hi_if.out_valid), 0);

    // ---- empty vector ----
    hi_if.in_vec = 16'h0000; hi_if.in_valid = 1'b1;
    step();
    hi_if.in_valid = 1'b0;
    chk("zero_pulse",    int'(hi_if.zero), 1);
    chk("zero_valid",    int'(hi_if.out_valid), 0);
    chk("zero_in_ready", int'(hi_if.in_ready), 1);
    step();
    chk("zero_one_cycle", int'(hi_if.zero), 0);
    chk("zero_valid2",    int'(hi_if.out_valid), 0);

    // ---- active-low instance ----
    lo_if.in_vec = 16'hFFFE; lo_if.in_valid = 1'b1;
    step();
    lo_if.in_valid = 1'b0; lo_if.in_vec = '1;
    chk("low_valid", int'(lo_if.out_valid), 1);
    chk("low_idx",   int'(lo_if.out_idx), 0);
    chk("low_last",  int'(lo_if.out_last), 1);
    step();
    chk("low_done", int'(lo_if.out_valid), 0);

    // ---- reset mid-drain, asserted between clock edges ----
    hi_if.in_vec = 16'hFFFF; hi_if.in_valid = 1'b1;
    step();
    hi_if.in_valid = 1'b0;
    chk("mr_first_idx", int'(hi_if.out_idx), 0);
    step();
    chk("mr_second_idx", int'(hi_if.out_idx), 1);
    #2 reset = 1'b1;
    #1;
    chk("mr_async_valid",    int'(hi_if.out_valid), 0);
    chk("mr_async_busy",     int'(hi_if.busy), 0);
    chk("mr_async_in_ready", int'(hi_if.in_ready), 1);
    chk("mr_async_idx",      int'(hi_if.out_idx), 0);
    step();
    reset = 1'b0;
    step();
    chk("mr_quiet", int'(hi_if.out_valid), 0);
    hi_if.in_vec = 16'h0001; hi_if.in_valid = 1'b1;
    step();
    hi_if.in_valid = 1'b0;
    chk("mr_new_valid", int'(hi_if.out_valid), 1);
    chk("mr_new_idx",   int'(hi_if.out_idx), 0);
    chk("mr_new_last",  int'(hi_if.out_last), 1);
    step();
    chk("mr_new_done", int'(hi_if.out_valid), 0);

    // ---- table of vectors at full rate ----
    hi_if.out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      hi_if.in_vec = tv[r].vec; hi_if.in_valid = 1'b1;
      step();
      hi_if.in_valid = 1'b0;
      n = 0; lasts = 0; got_first = 0; got_last = 0;
      zseen = hi_if.zero;
      for (int c = 0; c < 40 && hi_if.out_valid; c++) begin
        if (n == 0) got_first = int'(hi_if.out_idx);
        got_last = int'(hi_if.out_idx);
        if (hi_if.out_last) lasts++;
        n++;
        step();
      end
      chk("tbl_count", n, tv[r].count);
      chk("tbl_lasts", lasts, (tv[r].count > 0) ? 1 : 0);
      chk("tbl_zero", int'(zseen), (tv[r].count == 0) ? 1 : 0);
      chk("tbl_in_ready", int'(hi_if.in_ready), 1);
      if (tv[r].count > 0) begin
        chk("tbl_first", got_first, tv[r].first);
        chk("tbl_last_idx", got_last, tv[r].last);
      end
    end

    // ---- random vectors with random backpressure vs. an index-queue model ----
    q.delete();
    pend_zero = 1'b0; prev_stall = 1'b0; prev_idx = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_zero", int'(hi_if.zero), pend_zero ? 1 : 0);
      pend_zero = 1'b0;
      if (prev_stall) begin
        chk("rnd_hold_valid", int'(hi_if.out_valid), 1);
        chk("rnd_hold_idx",   int'(hi_if.out_idx), int'(prev_idx));
      end
      hi_if.in_valid = 1'b0;
      rdy = ($urandom_range(0, 2) != 0);
      hi_if.out_ready = rdy;
      if (hi_if.out_valid) begin
        if (rdy) begin
          if (q.size() == 0) begin
            chk("rnd_extra_output", q.size(), 1);
          end else begin
            exp_i = q.pop_front();
            chk("rnd_idx",  int'(hi_if.out_idx), exp_i);
            chk("rnd_last", int'(hi_if.out_last), (q.size() == 0) ? 1 : 0);
          end
        end
      end else begin
        chk("rnd_drained", q.size(), 0);
        if (hi_if.in_ready && $urandom_range(0, 1) == 1) begin
          v = rand_vec();
          hi_if.in_vec = v; hi_if.in_valid = 1'b1;
          for (int i = 0; i < OUT; i++) if ((v >> i) & 1) q.push_back(i);
          pend_zero = (v == '0);
        end
      end
      prev_stall = hi_if.out_valid && !rdy;
      prev_idx   = hi_if.out_idx;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
